// File: rtl/bird_pkg.sv
// +--------------------------------------------------------------------+
// | bird_pkg : shared state encoding and width helper for bird_column  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

  function automatic int pos_width(input int h);
    return $clog2(h);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bird_pos_step.sv
// +--------------------------------------------------------------------+
// | bird_pos_step : signed next-row arithmetic with floor/ceiling flags|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bird_pos_step
  import bird_pkg::*;
#(
  parameter int HEIGHT    = 8,
  parameter int FLAP_ROWS = 1
) (
  input  logic [pos_width(HEIGHT)-1:0] pos,
  input  logic                         press,
  input  logic                         gravity,
  output logic [pos_width(HEIGHT)-1:0] next_pos,
  output logic                         floor_hit,
  output logic                         ceil_hit
);

  localparam int PW = pos_width(HEIGHT);
  localparam int SW = PW + 2;

  logic signed [PW:0]   delta;
  logic signed [SW-1:0] sum;

  always_comb begin
    delta     = (press ? (PW+1)'(FLAP_ROWS) : '0) - (gravity ? (PW+1)'(1) : '0);
    // Two guard bits: one for sign, one for overshoot past the top row.
    sum       = $signed({2'b00, pos}) + $signed({delta[PW], delta});
    floor_hit = sum[SW-1];
    ceil_hit  = !sum[SW-1] && (sum > $signed(SW'(HEIGHT - 1)));
    if (floor_hit) begin
      next_pos = '0;
    end else if (ceil_hit) begin
      next_pos = PW'(HEIGHT - 1);
    end else begin
      next_pos = sum[PW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bird_column.sv
// +--------------------------------------------------------------------+
// | bird_column : bird row tracker driving a one-hot LED column.       |
// | Optional macro BIRD_CEILING_CRASH_EN turns top overshoot into death|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bird_column
  import bird_pkg::*;
#(
  parameter int HEIGHT    = 8,
  parameter int START_ROW = 3,
  parameter int FLAP_ROWS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         press,
  input  logic                         gravity,
  input  logic                         restart,
  output logic [HEIGHT-1:0]            lights,
  output logic [pos_width(HEIGHT)-1:0] pos,
  output logic                         playing,
  output logic                         dead
);

  localparam int PW = pos_width(HEIGHT);

  bird_state_t   state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          playing_q, playing_d;
  logic          dead_q, dead_d;
  logic [PW-1:0] step_pos;
  logic          floor_hit;
  logic          ceil_hit;

  bird_pos_step #(
    .HEIGHT    (HEIGHT),
    .FLAP_ROWS (FLAP_ROWS)
  ) u_step (
    .pos       (pos_q),
    .press     (press),
    .gravity   (gravity),
    .next_pos  (step_pos),
    .floor_hit (floor_hit),
    .ceil_hit  (ceil_hit)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = FLY;
      end
      FLY: begin
        pos_d = step_pos;
`ifdef BIRD_CEILING_CRASH_EN
        if (floor_hit || ceil_hit) state_d = DEAD;
`else
        if (floor_hit) state_d = DEAD;
`endif
      end
      DEAD: begin
        if (restart) begin
          state_d = IDLE;
          pos_d   = PW'(START_ROW);
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = PW'(START_ROW);
      end
    endcase
    playing_d = (state_d == FLY);
    dead_d    = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= PW'(START_ROW);
      playing_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      playing_q <= playing_d;
      dead_q    <= dead_d;
    end
  end

  assign lights  = HEIGHT'(1) << pos_q;
  assign pos     = pos_q;
  assign playing = playing_q;
  assign dead    = dead_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_column.sv
// +--------------------------------------------------------------------+
// | tb_bird_column : directed + random bench with a row/flag model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bird_column;

  localparam int H     = 8;
  localparam int START = 3;
  localparam int FLAP  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       press = 1'b0;
  logic       gravity = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] lights;
  logic [2:0] pos;
  logic       playing;
  logic       dead;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bird row as a plain integer plus two flags.
  int m_pos     = START;
  bit m_playing = 0;
  bit m_dead    = 0;

  bird_column #(
    .HEIGHT    (H),
    .START_ROW (START),
    .FLAP_ROWS (FLAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .press   (press),
    .gravity (gravity),
    .restart (restart),
    .lights  (lights),
    .pos     (pos),
    .playing (playing),
    .dead    (dead)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit p, input bit g, input bit rs);
    int n;
    if (r) begin
      m_pos = START; m_playing = 0; m_dead = 0;
    end else if (m_dead) begin
      if (rs) begin
        m_dead = 0; m_pos = START;
      end
    end else if (!m_playing) begin
      if (p) m_playing = 1;
    end else begin
      n = m_pos + (p ? FLAP : 0) - (g ? 1 : 0);
      if (n < 0) begin
        m_pos = 0; m_playing = 0; m_dead = 1;
      end else if (n > H - 1) begin
        m_pos = H - 1;
`ifdef BIRD_CEILING_CRASH_EN
        m_playing = 0; m_dead = 1;
`endif
      end else begin
        m_pos = n;
      end
    end
  endtask

  task automatic step(input bit r, input bit p, input bit g, input bit rs);
    reset = r; press = p; gravity = g; restart = rs;
    @(posedge clk);
    model_update(r, p, g, rs);
    #1;
    check_eq("pos", 32'(pos), 32'(m_pos));
    check_eq("lights", 32'(lights), 32'(1) << m_pos);
    check_eq("playing", 32'(playing), 32'(m_playing));
    check_eq("dead", 32'(dead), 32'(m_dead));
    check_eq("onehot", 32'($onehot(lights)), 32'd1);
  endtask

  initial begin
    // Reset, then gravity ignored in IDLE
    step(1, 0, 0, 0);
    check_eq("rst_pos", 32'(pos), 32'd3);
    check_eq("rst_lights", 32'(lights), 32'h08);
    repeat (3) step(0, 0, 1, 0);
    check_eq("idle_pos", 32'(pos), 32'd3);
    check_eq("idle_playing", 32'(playing), 32'd0);
    // Climb
    step(0, 1, 0, 0);
    check_eq("start_playing", 32'(playing), 32'd1);
    check_eq("start_pos", 32'(pos), 32'd3);
    step(0, 1, 0, 0);
    check_eq("climb_pos", 32'(pos), 32'd5);
    check_eq("climb_lights", 32'(lights), 32'h20);
    step(0, 1, 1, 0);
    check_eq("pg_pos", 32'(pos), 32'd6);
    // Ceiling behaviour depends on the build; model covers both
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    // Floor crash
    repeat (8) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 1);
    check_eq("restart_pos", 32'(pos), 32'd3);
    check_eq("restart_dead", 32'(dead), 32'd0);
    // Reset mid-flight
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    check_eq("midrst_pos", 32'(pos), 32'd3);
    check_eq("midrst_lights", 32'(lights), 32'h08);
    check_eq("midrst_playing", 32'(playing), 32'd0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 3) == 0,
           ($urandom % 2) == 0, ($urandom % 8) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bird_column.md
Name: bird_column

Overview:
- Parametrised successor of the single-LED bird cell: tracks the bird's vertical position in a column of HEIGHT LEDs.
- Moves the bird up on flap presses and down on gravity ticks, and drives a one-hot light column.
- Detects a floor crash, and a ceiling crash when the optional feature is compiled in.
- Sits between the input conditioner / gravity tick generator and the LED matrix driver; dead feeds the game controller.

Parameters:
- HEIGHT, 8, number of rows; row 0 = bottom, row HEIGHT-1 = top; legal range HEIGHT >= 2.
- START_ROW, 3, row loaded on reset and on restart; legal range START_ROW < HEIGHT.
- FLAP_ROWS, 1, rows climbed per press; legal range 1 <= FLAP_ROWS < HEIGHT.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- press  in  1  flap request, one-cycle pulse, already debounced and edge-detected upstream.
- gravity  in  1  fall tick, one-cycle pulse.
- restart  in  1  leave DEAD and return to IDLE.
- lights  out  HEIGHT  one-hot; bit pos is lit.
- pos  out  $clog2(HEIGHT)  current row, registered.
- playing  out  1  high in FLY.
- dead  out  1  high in DEAD.

Behaviour:
- Reset:
  - Synchronous, active-high, overrides every other input in the same cycle, including mid-flight and while DEAD.
  - Next edge gives state=IDLE, pos=START_ROW, lights=1<<START_ROW, playing=0, dead=0.
- Outputs:
  - pos, playing and dead are registered; lights is decoded combinationally from registered pos.
  - Any input sampled at edge N is visible after edge N (1-cycle latency).
- State IDLE:
  - gravity and restart are ignored; pos holds.
  - press -> FLY; the starting press does not move the bird.
- State FLY:
  - Compute delta = (press ? FLAP_ROWS : 0) - (gravity ? 1 : 0), signed, one bit wider than pos.
  - Compute next = pos + delta.
  - press and gravity together give net FLAP_ROWS-1; with FLAP_ROWS=1 the bird holds, matching the old cell.
  - next < 0, i.e. gravity at row 0 with no press: -> DEAD, pos stays 0.
  - next > HEIGHT-1: pos saturates to HEIGHT-1 and the state stays FLY. With the macro compiled in, this case instead goes -> DEAD (see Optional Feature).
  - Otherwise pos <= next.
  - restart is ignored in FLY.
- State DEAD:
  - pos frozen; press and gravity ignored.
  - restart -> IDLE with pos=START_ROW.
  - restart and press in the same cycle: go to IDLE only; the press is dropped.
- There is no path IDLE -> DEAD.
- The unused state encoding, if any, recovers to IDLE.
- lights is never all-zero and never has more than one bit set.

Optional Feature:
- Macro BIRD_CEILING_CRASH_EN.
- Defined: any FLY update with next > HEIGHT-1 goes -> DEAD with pos = HEIGHT-1. An update landing exactly on HEIGHT-1 is legal and stays FLY.
- Undefined: the same case saturates at HEIGHT-1 and stays FLY.
- The floor crash is unaffected either way.

Decomposition:
- Package bird_pkg holds:
  - typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;
  - localparam function pos_width(h) = $clog2(h).
- One sub-module, bird_pos_step (combinational):
  - Inputs: pos, press, gravity.
  - Outputs: next_pos, floor_hit, ceil_hit.
  - Does the signed delta arithmetic and clamping, keeping the FSM in bird_column free of arithmetic.
- bird_column contains the FSM, the pos register and the one-hot decode.

Test Plan (HEIGHT=8, START_ROW=3, FLAP_ROWS=2 unless stated):
1. Reset, then gravity for 3 cycles in IDLE -> pos=3, lights=8'b0000_1000, playing=0, dead=0 throughout.
2. Climb:
   - press -> playing=1, pos=3.
   - press -> pos=5, lights=8'b0010_0000.
   - press+gravity -> pos=6.
   - With FLAP_ROWS=1, press+gravity -> pos unchanged.
3. Ceiling, macro undefined:
   - press at pos=6 -> pos=7, playing=1.
   - press again -> pos=7, playing=1.
4. Floor crash:
   - From pos=7, 7 gravity ticks -> pos=0, still FLY.
   - 8th tick -> dead=1, playing=0, pos=0.
   - press/gravity while DEAD -> no change.
   - restart+press in one cycle -> IDLE, pos=3, dead=0.
5. Reset mid-flight:
   - At pos=5, assert reset together with press and gravity.
   - Next edge -> IDLE, pos=3, lights=8'b0000_1000.
6. Macro BIRD_CEILING_CRASH_EN defined:
   - press at pos=5 -> pos=7, FLY.
   - press at pos=6 -> dead=1, pos=7.
   - restart -> IDLE, pos=3.
